interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Drives the program counter's interrupt/recovery interface from the initiating side.
- Latches external IRQ edges and selects the highest-priority pending line.
- Issues the vector jump, captures the interrupted PC into a nesting stack, and on return-from-interrupt restores that PC by driving the recovery path with the PC lock asserted.

Parameters:
- N_IRQ, 8: number of interrupt lines; line 0 has the highest priority.
- STACK_DEPTH, 4: maximum nesting depth, i.e. number of saved {PC, level} entries.
- VECTOR_BASE, 16'hFF00: address of the line-0 vector.
- VECTOR_STRIDE, 16'h0010: address step between consecutive vectors.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- i_irq  in  N_IRQ  raw interrupt requests, rising-edge sensitive
- i_global_en  in  1  1 = dispatch allowed
- i_mask_we  in  1  mask register write strobe
- i_mask_data  in  N_IRQ  new mask value (1 = line enabled)
- i_return  in  1  one-cycle strobe from the decoder on return-from-interrupt
- i_save_pc  in  16  saved PC driven by the PC block while o_interrupt_enable is high
- o_interrupt_enable  out  1  one-cycle vector jump strobe
- o_interrupt_address  out  16  vector address, valid while o_interrupt_enable is high
- o_recovery_enable  out  1  one-cycle PC restore strobe
- o_recovery_pc  out  16  restored PC value, valid while o_recovery_enable is high
- o_pc_lock  out  1  high together with o_recovery_enable
- o_active_level  out  $clog2(N_IRQ+1)  current serviced line; N_IRQ = none
- o_depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries
- o_err  out  1  sticky error flag

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - all outputs 0, except o_active_level = N_IRQ;
  - pending bits 0, stack empty, mask all-ones, IRQ edge registers loaded with 0.
- Edge capture:
  - irq_q <= i_irq every cycle.
  - pending[k] is set when i_irq[k] & ~irq_q[k].
  - pending[k] is cleared in the cycle line k is dispatched; set has priority over clear on the same edge.
  - A held-high line raises only one request.
- Selection: best = lowest index k with pending[k] & mask[k].
- Dispatch eligibility: eligible = i_global_en & request exists & best < current level & depth < STACK_DEPTH.
- FSM states: IDLE, DISPATCH, RETURN.
  - IDLE -> RETURN when i_return=1 and depth>0. Return has priority over dispatch in the same cycle; dispatch is re-evaluated afterwards.
  - IDLE -> DISPATCH when eligible (and no valid return).
  - DISPATCH, 1 cycle:
    - Outputs: o_interrupt_enable=1; o_interrupt_address = VECTOR_BASE + sel*VECTOR_STRIDE, computed in 16 bits with wrap-around.
    - On the closing edge: push {i_save_pc, previous level}; level <= sel; clear pending[sel]; depth+1.
    - Next state: IDLE.
  - RETURN, 1 cycle:
    - Outputs: o_recovery_enable=1, o_pc_lock=1, o_recovery_pc = top.pc.
    - On the closing edge: level <= top.level; depth-1.
    - Next state: IDLE.
- Dispatch latency: 2 cycles from the i_irq rising edge to o_interrupt_enable (edge register, then DISPATCH).
- sel is registered on entry to DISPATCH. A new higher-priority edge arriving during DISPATCH is held pending and not lost.
- Error and edge cases:
  - i_return with depth=0: ignored, o_err <= 1 (sticky until reset).
  - i_return while in DISPATCH or RETURN: ignored, o_err <= 1.
  - Stack full with an eligible-priority request: no dispatch, request stays pending. No error.
- i_mask_we writes the mask at the edge. Masking a line does not clear its pending bit; it is dispatched once unmasked.
- Reset mid-DISPATCH or mid-RETURN: strobes drop the next cycle and there is no push or pop. The PC block is reset by the same event.

Optional Feature:
- Macro IRQ_CTRL_NMI_EN.
- Defined:
  - Line 0 is non-maskable: ignores mask[0] and i_global_en.
  - Line 0 preempts any level, including while level==0 (re-entrant NMI).
  - When the stack is full, an NMI sets o_err instead of silently waiting.
- Undefined: line 0 behaves like every other line.

Test Plan:
- Single IRQ: reset, i_global_en=1, pulse i_irq[3] with PC save value 16'h0042.
  - Required: o_interrupt_enable high for exactly 1 cycle, 2 cycles after the edge, with address 16'hFF30.
  - Required afterwards: o_depth=1, o_active_level=3.
- Return: after the single-IRQ case, pulse i_return.
  - Required: next cycle o_recovery_enable=o_pc_lock=1 and o_recovery_pc=16'h0042.
  - Required afterwards: o_depth=0, o_active_level=8.
- Nesting and priority:
  - While servicing line 3, raise line 5: no dispatch.
  - Raise line 1: dispatch to 16'hFF10, depth=2.
  - On return, level goes back to 3 and line 5 stays pending until the second return, then is dispatched.
- Overflow: with STACK_DEPTH=4, nest lines 6,5,4,3, then raise line 0 (macro undefined).
  - Required: no dispatch, o_err=0.
  - Required: after one return, line 0 is dispatched.
- Mask and global enable:
  - mask=8'hF7, pulse i_irq[3]: no dispatch.
  - Write mask=8'hFF: dispatch of line 3.
  - With i_global_en=0 nothing is dispatched until it returns high.
- Errors and simultaneous events:
  - i_return with an empty stack: o_err=1, no recovery strobe.
  - i_return in the same cycle as a new edge: RETURN occurs first, then the dispatch follows.

Source files
------------

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched priority interrupt controller with PC nesting stack
// Optional feature: define IRQ_CTRL_NMI_EN to make line 0 a re-entrant non-maskable interrupt.
module interrupt_controller #(
  parameter int          N_IRQ         = 8,
  parameter int          STACK_DEPTH   = 4,
  parameter logic [15:0] VECTOR_BASE   = 16'hFF00,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_IRQ-1:0]                   i_irq,
  input  logic                               i_global_en,
  input  logic                               i_mask_we,
  input  logic [N_IRQ-1:0]                   i_mask_data,
  input  logic                               i_return,
  input  logic [15:0]                        i_save_pc,
  output logic                               o_interrupt_enable,
  output logic [15:0]                        o_interrupt_address,
  output logic                               o_recovery_enable,
  output logic [15:0]                        o_recovery_pc,
  output logic                               o_pc_lock,
  output logic [$clog2(N_IRQ+1)-1:0]         o_active_level,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_depth,
  output logic                               o_err
);

  localparam int LW = $clog2(N_IRQ + 1);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LW-1:0] LVL_NONE  = LW'(N_IRQ);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_RETURN} state_t;

  state_t           state, state_n;
  logic [N_IRQ-1:0] irq_q, pending, mask, req_vec, clr_vec;
  logic [LW-1:0]    level, sel, best;
  logic [DW-1:0]    depth;
  logic             err;
  logic             has_req, has_room, nmi_req, eligible, ret_ok, ret_bad, nmi_full;
  logic [SW-1:0]    wr_idx, top_idx;

  logic [15:0]      stack_pc  [STACK_DEPTH];
  logic [LW-1:0]    stack_lvl [STACK_DEPTH];

  always_comb begin
    req_vec = pending & mask;
`ifdef IRQ_CTRL_NMI_EN
    req_vec[0] = pending[0];
`endif
    has_req = |req_vec;
    best    = LVL_NONE;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (req_vec[k]) best = LW'(k);
    end
  end

`ifdef IRQ_CTRL_NMI_EN
  assign nmi_req = pending[0];
`else
  assign nmi_req = 1'b0;
`endif

  assign has_room = (depth < DEPTH_MAX);
  // A pending NMI bypasses the enable and level checks; only stack space gates it.
  assign eligible = nmi_req ? has_room
                            : (i_global_en & has_req & (best < level) & has_room);
  assign ret_ok   = i_return & (depth != '0) & (state == ST_IDLE);
  assign ret_bad  = i_return & ~ret_ok;
  assign nmi_full = nmi_req & ~has_room & (state == ST_IDLE) & ~ret_ok;

  assign wr_idx  = SW'(depth);
  assign top_idx = SW'(depth - DW'(1));
  assign clr_vec = (state == ST_DISPATCH) ? ({{(N_IRQ-1){1'b0}}, 1'b1} << sel) : '0;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (ret_ok)        state_n = ST_RETURN;
        else if (eligible) state_n = ST_DISPATCH;
      end
      ST_DISPATCH: state_n = ST_IDLE;
      ST_RETURN:   state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
      level   <= LVL_NONE;
      depth   <= '0;
      sel     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      irq_q   <= i_irq;
      // New edges win over the dispatch clear on the same edge.
      pending <= (pending & ~clr_vec) | (i_irq & ~irq_q);
      if (i_mask_we) mask <= i_mask_data;
      if (state == ST_IDLE && state_n == ST_DISPATCH) sel <= best;
      if (state == ST_DISPATCH) begin
        level <= sel;
        depth <= depth + DW'(1);
      end else if (state == ST_RETURN) begin
        level <= stack_lvl[top_idx];
        depth <= depth - DW'(1);
      end
      if (ret_bad | nmi_full) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_DISPATCH) begin
      stack_pc[wr_idx]  <= i_save_pc;
      stack_lvl[wr_idx] <= level;
    end
  end

  assign o_interrupt_enable  = (state == ST_DISPATCH);
  assign o_interrupt_address = o_interrupt_enable ? (VECTOR_BASE + 16'(sel) * VECTOR_STRIDE) : 16'h0;
  assign o_recovery_enable   = (state == ST_RETURN);
  assign o_pc_lock           = (state == ST_RETURN);
  assign o_recovery_pc       = o_recovery_enable ? stack_pc[top_idx] : 16'h0;
  assign o_active_level      = level;
  assign o_depth             = depth;
  assign o_err               = err;

endmodule
